// File: rtl/alu_pkg.sv
// Shared ALU definitions: flag bit positions and default operand width,
// common to every logic/arithmetic unit built on alu_flag_gen.
package alu_pkg;

    localparam int ALU_DEFAULT_W = 8;

    localparam int FLAG_W = 4;
    localparam int N_BIT  = 3;
    localparam int Z_BIT  = 2;
    localparam int V_BIT  = 1;
    localparam int C_BIT  = 0;

endpackage : alu_pkg

// File: rtl/alu_flag_gen.sv
// Status flag generator for logical results: N from the MSB, Z when the
// whole result is zero. V and C are tied low since logical operations
// produce neither overflow nor carry. Purely combinational.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int W = ALU_DEFAULT_W
) (
    input  logic [W-1:0]      res_i,
    output logic [FLAG_W-1:0] flags_o
);

    // Assemble the flag vector from the result
    always_comb begin
        flags_o        = '0;
        flags_o[N_BIT] = res_i[W-1];
        flags_o[Z_BIT] = ~|res_i;
        flags_o[V_BIT] = 1'b0;
        flags_o[C_BIT] = 1'b0;
    end

endmodule : alu_flag_gen

// File: rtl/xor_bitwise_nbit.sv
// N-bit bitwise XOR unit with registered result, flags and valid.
// One-cycle latency, one operation per clock. Flags are derived from the
// same next-state value that is loaded into the result register, so out
// and flags always update together. All outputs come straight from flops.
module xor_bitwise_nbit
    import alu_pkg::*;
#(
    parameter int N = ALU_DEFAULT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [N-1:0]      in_a,
    input  logic [N-1:0]      in_b,
    output logic [N-1:0]      out,
    output logic [FLAG_W-1:0] flags_n_z_v_c,
    output logic              out_valid
);

    logic [N-1:0]      xor_res;
    logic [FLAG_W-1:0] xor_flags;

    logic [N-1:0]      out_q,   out_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              vld_q,   vld_d;

    assign xor_res = in_a ^ in_b;

    alu_flag_gen #(
        .W       (N)
    ) u_flag_gen (
        .res_i   (xor_res),
        .flags_o (xor_flags)
    );

    // Load a new result and its flags on accepted operations, else hold
    always_comb begin
        out_d   = out_q;
        flags_d = flags_q;
        vld_d   = in_valid;
        if (in_valid) begin
            out_d   = xor_res;
            flags_d = xor_flags;
        end
    end

    // Result, flag and valid registers; reset clears everything at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            flags_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            flags_q <= flags_d;
            vld_q   <= vld_d;
        end
    end

    assign out           = out_q;
    assign flags_n_z_v_c = flags_q;
    assign out_valid     = vld_q;

endmodule : xor_bitwise_nbit

// File: tb/tb_xor_bitwise_nbit.sv
// Bench for xor_bitwise_nbit at widths 8, 1 and 16 driven in parallel.
// Stimulus pushes expected responses into per-width queues; monitors pop
// and compare whenever a DUT asserts out_valid.
module tb_xor_bitwise_nbit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] sa, sb;

    logic [7:0]  o8;   logic [3:0] f8;  logic ov8;
    logic [0:0]  o1;   logic [3:0] f1;  logic ov1;
    logic [15:0] o16;  logic [3:0] f16; logic ov16;

    int total  = 0;
    int passed = 0;

    logic [19:0] q8[$];
    logic [19:0] q1[$];
    logic [19:0] q16[$];

    xor_bitwise_nbit #(.N(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_a(sa[7:0]), .in_b(sb[7:0]),
        .out(o8), .flags_n_z_v_c(f8), .out_valid(ov8)
    );

    xor_bitwise_nbit #(.N(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_a(sa[0:0]), .in_b(sb[0:0]),
        .out(o1), .flags_n_z_v_c(f1), .out_valid(ov1)
    );

    xor_bitwise_nbit #(.N(16)) u16 (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_a(sa), .in_b(sb),
        .out(o16), .flags_n_z_v_c(f16), .out_valid(ov16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: w-bit XOR via arithmetic masking; negative means the value
    // is at least half the range, zero means the value equals zero.
    function automatic logic [19:0] model(input int w, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] r;
        logic [31:0] half;
        r    = (32'(a) ^ 32'(b)) % (32'd1 << w);
        half = 32'd1 << (w - 1);
        return {(r >= half), (r == 32'd0), 2'b00, r[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h expected=%h", nm, got, exp);
    endtask

    task automatic chk_resp(input string nm, input logic [15:0] got_o, input logic [3:0] got_f,
                            input logic [19:0] exp);
        total++;
        if ({got_f, got_o} === exp) passed++;
        else $display("FAIL %s out=%h flags=%b expected out=%h flags=%b",
                      nm, got_o, got_f, exp[15:0], exp[19:16]);
    endtask

    // Monitors: one per width, compare on every presented result
    always @(negedge clk) begin
        if (ov8 === 1'b1) begin
            if (q8.size() == 0) chk("unexpected_valid_n8", 32'd1, 32'd0);
            else chk_resp("resp_n8", {8'h00, o8}, f8, q8.pop_front());
        end
    end

    always @(negedge clk) begin
        if (ov1 === 1'b1) begin
            if (q1.size() == 0) chk("unexpected_valid_n1", 32'd1, 32'd0);
            else chk_resp("resp_n1", {15'h0, o1}, f1, q1.pop_front());
        end
    end

    always @(negedge clk) begin
        if (ov16 === 1'b1) begin
            if (q16.size() == 0) chk("unexpected_valid_n16", 32'd1, 32'd0);
            else chk_resp("resp_n16", o16, f16, q16.pop_front());
        end
    end

    // Drive one operation and record its expected response for each width;
    // returns 1ns after the accepting edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        sa       = a;
        sb       = b;
        in_valid = 1'b1;
        q8.push_back(model(8, a, b));
        q1.push_back(model(1, a, b));
        q16.push_back(model(16, a, b));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_n8"},  {19'h0, ov8,  f8,  o8},  32'h0);
        chk({nm, "_n1"},  {26'h0, ov1,  f1,  o1},  32'h0);
        chk({nm, "_n16"}, {11'h0, ov16, f16, o16}, 32'h0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        sa       = '0;
        sb       = '0;
        #1;
        chk_all_zero("reset_async");
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_clocked");
        rst = 1'b0;

        // Directed cases with hard-coded expectations
        issue(16'h0000, 16'h0000);
        chk("zero_xor_n8", {19'h0, ov8, f8, o8}, {19'h0, 1'b1, 4'b0100, 8'h00});
        issue(16'h0001, 16'h0000);
        chk("one_xor_zero_n8", {f8, o8}, {4'b0000, 8'h01});
        chk("one_xor_zero_n1", {f1, o1}, {4'b1000, 1'b1});
        issue(16'h0001, 16'h0001);
        chk("one_xor_one_n8", {f8, o8}, {4'b0100, 8'h00});
        chk("one_xor_one_n1", {f1, o1}, {4'b0100, 1'b0});
        issue(16'h0003, 16'h0004);
        chk("three_xor_four_n8", {ov8, f8, o8}, {1'b1, 4'b0000, 8'h07});
        issue(16'h000F, 16'h000F);
        chk("b2b_second_n8", {ov8, f8, o8}, {1'b1, 4'b0100, 8'h00});
        issue(16'h0080, 16'h0000);
        chk("msb_only_n8", {f8, o8}, {4'b1000, 8'h80});
        issue(16'h00FF, 16'h000F);
        chk("high_nibble_n8", {f8, o8}, {4'b1000, 8'hF0});
        issue(16'h005A, 16'h0000);
        chk("pre_hold_n8", {f8, o8}, {4'b0000, 8'h5A});

        // Hold: no new operations for three cycles
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("hold_n8", {ov8, f8, o8}, {1'b0, 4'b0000, 8'h5A});
        end

        // Reset mid-stream: accepted result and later ops must be dropped
        issue(16'(($urandom)), 16'(($urandom)));
        issue(16'hFFFF, 16'h0001);
        rst = 1'b1;
        q8.delete();
        q1.delete();
        q16.delete();
        #1;
        chk_all_zero("reset_midstream");
        sa = 16'h1234;
        sb = 16'h4321;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_held_with_valid");
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_all_zero("no_stale_after_reset");
        issue(16'h00A5, 16'h000F);
        chk("first_after_reset_n8", {ov8, f8, o8}, {1'b1, 4'b1000, 8'hAA});

        // Randomised operands, checked by the monitors against the model
        for (int i = 0; i < 1000; i++) begin
            issue(16'($urandom), 16'($urandom));
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("drain_n8",  32'(q8.size()),  32'd0);
        chk("drain_n1",  32'(q1.size()),  32'd0);
        chk("drain_n16", 32'(q16.size()), 32'd0);
        chk("idle_valid", {29'h0, ov8, ov1, ov16}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_xor_bitwise_nbit

// File: doc/xor_bitwise_nbit.md
XOR_BITWISE_NBIT -- requirements
Module: xor_bitwise_nbit

Interface
REQ-001 Parameter N, default 8: operand and result width in bits; SHALL be legal for any N >= 1.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous reset, active-high.
REQ-005 in_valid  input  1  qualifies in_a/in_b on the current rising edge.
REQ-006 in_a  input  N  operand A.
REQ-007 in_b  input  N  operand B.
REQ-008 out  output  N  registered bitwise XOR result.
REQ-009 flags_n_z_v_c  output  4  registered status flags: bit3=N (negative), bit2=Z (zero), bit1=V (overflow), bit0=C (carry).
REQ-010 out_valid  output  1  high for one cycle per accepted operation, aligned with out and flags.

Function
REQ-011 On a rising edge with in_valid=1, out SHALL load in_a ^ in_b, bit by bit.
REQ-012 Latency SHALL be exactly one cycle: the result is visible after the edge that samples the operands.
REQ-013 out_valid SHALL follow in_valid with one cycle of delay; back-to-back operations SHALL be accepted every cycle, so throughput is 1 per clock.
REQ-014 With in_valid=0, out and flags_n_z_v_c SHALL hold their previous values, and out_valid SHALL be 0.
REQ-015 The N flag SHALL equal bit N-1 of the new result.
REQ-016 The Z flag SHALL be 1 if and only if all N result bits are 0.
REQ-017 The V and C flags SHALL always be 0, because a logical operation produces no overflow or carry.
REQ-018 Flags SHALL be computed from the same result loaded into out and SHALL update in the same edge as out.
REQ-019 For N=1, the N flag SHALL equal the single result bit, and Z SHALL be its inverse.
REQ-020 There SHALL be no combinational path from any input to any output.

Reset
REQ-021 While rst=1: out=0, flags_n_z_v_c=4'b0000, out_valid=0, applied immediately and independent of clk.
REQ-022 An operation in flight when rst asserts SHALL be discarded and SHALL NOT appear after reset deasserts.
REQ-023 The first edge after rst deasserts with in_valid=1 SHALL be accepted normally.

Structure
REQ-024 The flag bit positions (N_BIT=3, Z_BIT=2, V_BIT=1, C_BIT=0) SHALL be constants in the shared ALU package, common to all ALU blocks.
REQ-025 The default width constant of 8 SHALL reside in that package.
REQ-026 Flag generation SHALL be one sub-module, alu_flag_gen (N-bit result in, 4-bit flags out, V/C tied 0), so sibling logic units can reuse it.
REQ-027 The datapath SHALL be N-bit vector XOR followed by a single register stage; no other sub-modules.

Verification
REQ-028 N=8, reset, then in_valid=1, a=0, b=0 -> after 1 cycle: out=00000000, flags=0100, out_valid=1.
REQ-029 N=8, a=00000001, b=00000000 -> out=00000001, flags=0000; then a=1, b=1 -> out=00000000, flags=0100.
REQ-030 N=8, a=3, b=4 -> out=00000111, flags=0000; then a=15, b=15 -> out=00000000, flags=0100; results arrive on consecutive cycles.
REQ-031 N=8, a=8'h80, b=8'h00 -> out=10000000, flags=1000; then a=8'hFF, b=8'h0F -> out=11110000, flags=1000.
REQ-032 Hold and reset:
- After an operation giving out=8'h5A, drive in_valid=0 for 3 cycles -> out stays 8'h5A and out_valid=0.
- Assert rst mid-stream -> out=0 and flags=0000 immediately, with no stale result after release.
REQ-033 Width and randomised checks:
- N=1: a=1, b=0 -> out=1, flags=1000.
- N=16: 1000 random operand pairs -> out == a^b, Z/N checked against a model, V=C=0 always.
